ip_tx_nexthop_resolve: RTL and testbench
========================================

Name: ip_tx_nexthop_resolve

Overview:
- IPv4 transmit-side next-hop resolver between the user IP header/payload source and ip_eth_tx.
- Accepts an IP header and selects the next hop: on-subnet destination or gateway. Broadcast and multicast MACs are derived directly with no ARP.
- Otherwise resolves the MAC via the ARP request/response port, with timeout and retry.
- Forwards the header with the resolved eth_dest_mac and passes the AXI-stream payload through. On failure the payload is dropped.

Parameters:
DATA_WIDTH, 8, payload tdata width in bits (multiple of 8)
KEEP_WIDTH, DATA_WIDTH/8, tkeep width
ARP_TIMEOUT, 65536, cycles to wait for an ARP response per attempt (>=2)
ARP_RETRIES, 2, extra request attempts after the first times out (0 = single attempt)
COUNT_WIDTH, 16, width of the status counters

Ports:
clk  in  1  clock
rst_n  in  1  synchronous reset, active low
s_ip_hdr_valid/s_ip_hdr_ready  in/out  1  input header handshake
s_ip_dscp,s_ip_ecn,s_ip_length,s_ip_ttl,s_ip_protocol  in  6,2,16,8,8  header fields
s_ip_source_ip,s_ip_dest_ip  in  32  addresses
s_ip_payload_axis_tdata/tkeep/tvalid/tready/tlast/tuser  in(tready out)  DATA_WIDTH/KEEP_WIDTH/1/1/1/1  payload in
m_ip_hdr_valid/m_ip_hdr_ready  out/in  1  output header handshake
m_eth_dest_mac,m_eth_src_mac,m_eth_type  out  48,48,16  src=local_mac, type=16'h0800
m_ip_dscp,m_ip_ecn,m_ip_length,m_ip_ttl,m_ip_protocol,m_ip_source_ip,m_ip_dest_ip  out  as input  registered copies
m_ip_payload_axis_tdata/tkeep/tvalid/tready/tlast/tuser  out(tready in)  as input  payload out
arp_request_valid/arp_request_ready  out/in  1  ARP request handshake
arp_request_ip  out  32  next-hop IP
arp_response_valid/arp_response_ready  in/out  1  ARP response handshake
arp_response_error  in  1  ARP lookup failed
arp_response_mac  in  48  resolved MAC
local_mac,local_ip,gateway_ip,subnet_mask  in  48,32,32,32  configuration, sampled at header accept
busy  out  1  high in any state other than IDLE
error_arp_failed,error_arp_timeout  out  1  one-cycle pulses
tx_packet_count,drop_count  out  COUNT_WIDTH  saturating counters

Behaviour:
- Reset (rst_n low at a clk edge, any state): state=IDLE, all valid/ready outputs 0, error pulses 0, counters 0, timeout/retry counters 0. An in-flight packet is abandoned; no recovery is attempted.
- s_ip_hdr_ready is registered and is 1 only in IDLE. On handshake, all header fields and the config inputs are captured.
- Next hop, evaluated in priority order on the captured values:
  - dest==FFFFFFFF, or (dest & ~mask)==~mask with (dest^local_ip)&mask==0: MAC=FF:FF:FF:FF:FF:FF, go to HDR.
  - dest[31:28]==4'hE: MAC={24'h01005E,1'b0,dest[22:0]}, go to HDR.
  - (dest^local_ip)&mask==0: arp_ip=dest, go to ARP_REQ.
  - else: arp_ip=gateway_ip, go to ARP_REQ.
- ARP_REQ:
  - arp_request_valid=1 until arp_request_ready; then load the timeout counter to ARP_TIMEOUT-1 and go to ARP_WAIT.
  - arp_request_ip holds the captured next hop throughout.
- ARP_WAIT: arp_response_ready=1; the counter decrements each cycle.
  - Response valid, no error: latch MAC, go to HDR.
  - Response valid with error: error_arp_failed pulse, go to DROP.
  - Counter==0 with no response: if retries_used<ARP_RETRIES, increment retries_used and go to ARP_REQ; else error_arp_timeout pulse, go to DROP.
  - A response and expiry in the same cycle: the response wins.
- HDR: m_ip_hdr_valid=1 until m_ip_hdr_ready, then go to PAYLOAD.
- PAYLOAD:
  - Combinational pass-through: s tready = m tready; m tvalid = s tvalid; tdata/tkeep/tlast/tuser forwarded.
  - On the tlast handshake: tx_packet_count++, go to IDLE.
- DROP: s tready=1, m tvalid=0. On the tlast beat: drop_count++, go to IDLE.
- In IDLE, ARP_REQ, ARP_WAIT and HDR: s tready=0 and m tvalid=0.
- Counters saturate at all-ones and do not wrap.
- Header-to-header latency: the next s_ip_hdr_ready rises the cycle after the tlast beat.

Test Plan:
- local_ip=192.168.1.10, mask=FFFFFF00, dest=192.168.1.20, 4-beat payload, ARP returns 02:00:00:00:00:20 after 5 cycles -> arp_request_ip=C0A80114; m_eth_dest_mac=020000000020; 4 beats out unchanged; tx_packet_count=1.
- dest=8.8.8.8, gateway_ip=192.168.1.1 -> arp_request_ip=C0A80101; the resolved MAC appears on m_eth_dest_mac.
- dest=239.1.2.3 -> no ARP request issued; m_eth_dest_mac=01005E010203. dest=192.168.1.255 -> m_eth_dest_mac=FFFFFFFFFFFF.
- ARP_TIMEOUT=16, ARP_RETRIES=2, no response -> 3 requests spaced by 16-cycle waits, then one error_arp_timeout pulse; payload consumed with m tvalid low; drop_count=1.
- ARP response with error=1 -> error_arp_failed pulse; packet dropped. Response asserted in the cycle the counter hits 0 -> accepted, no retry.
- m tready toggling 1/0 in PAYLOAD -> no beat lost or duplicated. rst_n low mid-PAYLOAD -> next cycle busy=0, all valids 0, counters 0, s_ip_hdr_ready=1.

Source files
------------

// File: rtl/ip_tx_nexthop_resolve.sv
// IPv4 transmit next-hop resolver: picks the on-subnet destination or the gateway,
// resolves its MAC (directly for broadcast/multicast, otherwise via ARP with retry), then forwards header and payload.
module ip_tx_nexthop_resolve #(
  parameter int DATA_WIDTH  = 8,
  parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter int ARP_TIMEOUT = 65536,
  parameter int ARP_RETRIES = 2,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s_ip_hdr_valid,
  output logic                   s_ip_hdr_ready,
  input  logic [5:0]             s_ip_dscp,
  input  logic [1:0]             s_ip_ecn,
  input  logic [15:0]            s_ip_length,
  input  logic [7:0]             s_ip_ttl,
  input  logic [7:0]             s_ip_protocol,
  input  logic [31:0]            s_ip_source_ip,
  input  logic [31:0]            s_ip_dest_ip,
  input  logic [DATA_WIDTH-1:0]  s_ip_payload_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]  s_ip_payload_axis_tkeep,
  input  logic                   s_ip_payload_axis_tvalid,
  output logic                   s_ip_payload_axis_tready,
  input  logic                   s_ip_payload_axis_tlast,
  input  logic                   s_ip_payload_axis_tuser,
  output logic                   m_ip_hdr_valid,
  input  logic                   m_ip_hdr_ready,
  output logic [47:0]            m_eth_dest_mac,
  output logic [47:0]            m_eth_src_mac,
  output logic [15:0]            m_eth_type,
  output logic [5:0]             m_ip_dscp,
  output logic [1:0]             m_ip_ecn,
  output logic [15:0]            m_ip_length,
  output logic [7:0]             m_ip_ttl,
  output logic [7:0]             m_ip_protocol,
  output logic [31:0]            m_ip_source_ip,
  output logic [31:0]            m_ip_dest_ip,
  output logic [DATA_WIDTH-1:0]  m_ip_payload_axis_tdata,
  output logic [KEEP_WIDTH-1:0]  m_ip_payload_axis_tkeep,
  output logic                   m_ip_payload_axis_tvalid,
  input  logic                   m_ip_payload_axis_tready,
  output logic                   m_ip_payload_axis_tlast,
  output logic                   m_ip_payload_axis_tuser,
  output logic                   arp_request_valid,
  input  logic                   arp_request_ready,
  output logic [31:0]            arp_request_ip,
  input  logic                   arp_response_valid,
  output logic                   arp_response_ready,
  input  logic                   arp_response_error,
  input  logic [47:0]            arp_response_mac,
  input  logic [47:0]            local_mac,
  input  logic [31:0]            local_ip,
  input  logic [31:0]            gateway_ip,
  input  logic [31:0]            subnet_mask,
  output logic                   busy,
  output logic                   error_arp_failed,
  output logic                   error_arp_timeout,
  output logic [COUNT_WIDTH-1:0] tx_packet_count,
  output logic [COUNT_WIDTH-1:0] drop_count
);

  localparam int TW = $clog2(ARP_TIMEOUT);
  localparam int RW = $clog2(ARP_RETRIES + 2);

  // Handshakes: a transfer happens on a rising clk edge where valid and ready are both high.
  typedef enum logic [2:0] {
    ST_IDLE, ST_ARP_REQ, ST_ARP_WAIT, ST_HDR, ST_PAYLOAD, ST_DROP
  } state_t;

  typedef struct packed {
    logic [5:0]  dscp;
    logic [1:0]  ecn;
    logic [15:0] length;
    logic [7:0]  ttl;
    logic [7:0]  protocol;
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [47:0] src_mac;
  } hdr_t;

  state_t                 state_q, state_d;
  hdr_t                   hdr_q, hdr_d;
  logic                   hdr_ready_q, hdr_ready_d;
  logic [47:0]            mac_q, mac_d;
  logic [31:0]            arp_ip_q, arp_ip_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic [RW-1:0]          retry_q, retry_d;
  logic                   fail_q, fail_d;
  logic                   timeout_q, timeout_d;
  logic [COUNT_WIDTH-1:0] tx_cnt_q, tx_cnt_d;
  logic [COUNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

  logic on_subnet, is_bcast, is_mcast, hdr_hs;

  assign on_subnet = ((s_ip_dest_ip ^ local_ip) & subnet_mask) == 32'd0;
  assign is_bcast  = (s_ip_dest_ip == 32'hFFFF_FFFF) ||
                     (((s_ip_dest_ip & ~subnet_mask) == ~subnet_mask) && on_subnet);
  assign is_mcast  = s_ip_dest_ip[31:28] == 4'hE;
  assign hdr_hs    = s_ip_hdr_valid && hdr_ready_q;

  always_comb begin
    state_d    = state_q;
    hdr_d      = hdr_q;
    mac_d      = mac_q;
    arp_ip_d   = arp_ip_q;
    tmo_d      = tmo_q;
    retry_d    = retry_q;
    fail_d     = 1'b0;
    timeout_d  = 1'b0;
    tx_cnt_d   = tx_cnt_q;
    drop_cnt_d = drop_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (hdr_hs) begin
          hdr_d   = '{dscp: s_ip_dscp, ecn: s_ip_ecn, length: s_ip_length, ttl: s_ip_ttl,
                      protocol: s_ip_protocol, src_ip: s_ip_source_ip, dst_ip: s_ip_dest_ip,
                      src_mac: local_mac};
          retry_d = '0;
          if (is_bcast) begin
            mac_d   = 48'hFFFF_FFFF_FFFF;
            state_d = ST_HDR;
          end else if (is_mcast) begin
            mac_d   = {24'h01005E, 1'b0, s_ip_dest_ip[22:0]};
            state_d = ST_HDR;
          end else begin
            arp_ip_d = on_subnet ? s_ip_dest_ip : gateway_ip;
            state_d  = ST_ARP_REQ;
          end
        end
      end
      ST_ARP_REQ: begin
        if (arp_request_ready) begin
          tmo_d   = TW'(ARP_TIMEOUT - 1);
          state_d = ST_ARP_WAIT;
        end
      end
      ST_ARP_WAIT: begin
        // A response arriving in the expiry cycle takes precedence over the timeout.
        if (arp_response_valid) begin
          if (arp_response_error) begin
            fail_d  = 1'b1;
            state_d = ST_DROP;
          end else begin
            mac_d   = arp_response_mac;
            state_d = ST_HDR;
          end
        end else if (tmo_q == '0) begin
          if (32'(retry_q) < ARP_RETRIES) begin
            retry_d = retry_q + RW'(1);
            state_d = ST_ARP_REQ;
          end else begin
            timeout_d = 1'b1;
            state_d   = ST_DROP;
          end
        end else begin
          tmo_d = tmo_q - TW'(1);
        end
      end
      ST_HDR: begin
        if (m_ip_hdr_ready) state_d = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        if (s_ip_payload_axis_tvalid && m_ip_payload_axis_tready && s_ip_payload_axis_tlast) begin
          if (tx_cnt_q != '1) tx_cnt_d = tx_cnt_q + COUNT_WIDTH'(1);
          state_d = ST_IDLE;
        end
      end
      ST_DROP: begin
        if (s_ip_payload_axis_tvalid && s_ip_payload_axis_tlast) begin
          if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + COUNT_WIDTH'(1);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Registered ready, so it is already high the cycle after a packet completes.
    hdr_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      hdr_q       <= '0;
      hdr_ready_q <= 1'b0;
      mac_q       <= '0;
      arp_ip_q    <= '0;
      tmo_q       <= '0;
      retry_q     <= '0;
      fail_q      <= 1'b0;
      timeout_q   <= 1'b0;
      tx_cnt_q    <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      hdr_q       <= hdr_d;
      hdr_ready_q <= hdr_ready_d;
      mac_q       <= mac_d;
      arp_ip_q    <= arp_ip_d;
      tmo_q       <= tmo_d;
      retry_q     <= retry_d;
      fail_q      <= fail_d;
      timeout_q   <= timeout_d;
      tx_cnt_q    <= tx_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign s_ip_hdr_ready     = hdr_ready_q;
  assign busy               = (state_q != ST_IDLE);
  assign arp_request_valid  = (state_q == ST_ARP_REQ);
  assign arp_request_ip     = arp_ip_q;
  assign arp_response_ready = (state_q == ST_ARP_WAIT);
  assign error_arp_failed   = fail_q;
  assign error_arp_timeout  = timeout_q;
  assign tx_packet_count    = tx_cnt_q;
  assign drop_count         = drop_cnt_q;

  assign m_ip_hdr_valid = (state_q == ST_HDR);
  assign m_eth_dest_mac = mac_q;
  assign m_eth_src_mac  = hdr_q.src_mac;
  assign m_eth_type     = 16'h0800;
  assign m_ip_dscp      = hdr_q.dscp;
  assign m_ip_ecn       = hdr_q.ecn;
  assign m_ip_length    = hdr_q.length;
  assign m_ip_ttl       = hdr_q.ttl;
  assign m_ip_protocol  = hdr_q.protocol;
  assign m_ip_source_ip = hdr_q.src_ip;
  assign m_ip_dest_ip   = hdr_q.dst_ip;

  assign s_ip_payload_axis_tready = ((state_q == ST_PAYLOAD) && m_ip_payload_axis_tready) ||
                                    (state_q == ST_DROP);
  assign m_ip_payload_axis_tvalid = (state_q == ST_PAYLOAD) && s_ip_payload_axis_tvalid;
  assign m_ip_payload_axis_tdata  = s_ip_payload_axis_tdata;
  assign m_ip_payload_axis_tkeep  = s_ip_payload_axis_tkeep;
  assign m_ip_payload_axis_tlast  = s_ip_payload_axis_tlast;
  assign m_ip_payload_axis_tuser  = s_ip_payload_axis_tuser;

endmodule

// File: tb/tb_ip_tx_nexthop_resolve.sv
// Directed bench for ip_tx_nexthop_resolve: inputs change 1ns after posedge, outputs sampled on negedge.
module tb_ip_tx_nexthop_resolve;
  localparam int DW = 8;
  localparam int KW = 1;
  localparam int TMO = 16;
  localparam int RET = 2;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic s_ip_hdr_valid, s_ip_hdr_ready;
  logic [5:0] s_ip_dscp;
  logic [1:0] s_ip_ecn;
  logic [15:0] s_ip_length;
  logic [7:0] s_ip_ttl, s_ip_protocol;
  logic [31:0] s_ip_source_ip, s_ip_dest_ip;
  logic [DW-1:0] s_tdata, m_tdata;
  logic [KW-1:0] s_tkeep, m_tkeep;
  logic s_tvalid, s_tready, s_tlast, s_tuser;
  logic m_tvalid, m_tready, m_tlast, m_tuser;
  logic m_ip_hdr_valid, m_ip_hdr_ready;
  logic [47:0] m_eth_dest_mac, m_eth_src_mac;
  logic [15:0] m_eth_type, m_ip_length;
  logic [5:0] m_ip_dscp;
  logic [1:0] m_ip_ecn;
  logic [7:0] m_ip_ttl, m_ip_protocol;
  logic [31:0] m_ip_source_ip, m_ip_dest_ip;
  logic arp_request_valid, arp_request_ready;
  logic [31:0] arp_request_ip;
  logic arp_response_valid, arp_response_ready, arp_response_error;
  logic [47:0] arp_response_mac;
  logic [47:0] local_mac;
  logic [31:0] local_ip, gateway_ip, subnet_mask;
  logic busy, error_arp_failed, error_arp_timeout;
  logic [CW-1:0] tx_packet_count, drop_count;

  ip_tx_nexthop_resolve #(
    .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ARP_TIMEOUT(TMO), .ARP_RETRIES(RET), .COUNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_ip_hdr_valid(s_ip_hdr_valid), .s_ip_hdr_ready(s_ip_hdr_ready),
    .s_ip_dscp(s_ip_dscp), .s_ip_ecn(s_ip_ecn), .s_ip_length(s_ip_length),
    .s_ip_ttl(s_ip_ttl), .s_ip_protocol(s_ip_protocol),
    .s_ip_source_ip(s_ip_source_ip), .s_ip_dest_ip(s_ip_dest_ip),
    .s_ip_payload_axis_tdata(s_tdata), .s_ip_payload_axis_tkeep(s_tkeep),
    .s_ip_payload_axis_tvalid(s_tvalid), .s_ip_payload_axis_tready(s_tready),
    .s_ip_payload_axis_tlast(s_tlast), .s_ip_payload_axis_tuser(s_tuser),
    .m_ip_hdr_valid(m_ip_hdr_valid), .m_ip_hdr_ready(m_ip_hdr_ready),
    .m_eth_dest_mac(m_eth_dest_mac), .m_eth_src_mac(m_eth_src_mac), .m_eth_type(m_eth_type),
    .m_ip_dscp(m_ip_dscp), .m_ip_ecn(m_ip_ecn), .m_ip_length(m_ip_length),
    .m_ip_ttl(m_ip_ttl), .m_ip_protocol(m_ip_protocol),
    .m_ip_source_ip(m_ip_source_ip), .m_ip_dest_ip(m_ip_dest_ip),
    .m_ip_payload_axis_tdata(m_tdata), .m_ip_payload_axis_tkeep(m_tkeep),
    .m_ip_payload_axis_tvalid(m_tvalid), .m_ip_payload_axis_tready(m_tready),
    .m_ip_payload_axis_tlast(m_tlast), .m_ip_payload_axis_tuser(m_tuser),
    .arp_request_valid(arp_request_valid), .arp_request_ready(arp_request_ready),
    .arp_request_ip(arp_request_ip),
    .arp_response_valid(arp_response_valid), .arp_response_ready(arp_response_ready),
    .arp_response_error(arp_response_error), .arp_response_mac(arp_response_mac),
    .local_mac(local_mac), .local_ip(local_ip), .gateway_ip(gateway_ip), .subnet_mask(subnet_mask),
    .busy(busy), .error_arp_failed(error_arp_failed), .error_arp_timeout(error_arp_timeout),
    .tx_packet_count(tx_packet_count), .drop_count(drop_count)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int n_chk = 0;
  int n_fail = 0;
  logic [10:0] exp_q[$];
  logic [10:0] got_q[$];
  int got_idx = 0;
  int req_cnt = 0, hdr_cnt = 0, tmo_pulses = 0, fail_pulses = 0, tmo_cyc = 0;
  int req_cyc[$];
  logic [31:0] last_req_ip;
  logic [47:0] hdr_mac, hdr_src;
  logic [15:0] hdr_type, hdr_len;
  logic [31:0] hdr_dst;
  logic [55:0] hdr_misc;

  // Monitors: sole writers of the observation variables.
  always @(negedge clk) begin
    if (arp_request_valid && arp_request_ready) begin
      req_cnt++;
      last_req_ip = arp_request_ip;
      req_cyc.push_back(cyc);
    end
    if (m_ip_hdr_valid && m_ip_hdr_ready) begin
      hdr_cnt++;
      hdr_mac  = m_eth_dest_mac;
      hdr_src  = m_eth_src_mac;
      hdr_type = m_eth_type;
      hdr_len  = m_ip_length;
      hdr_dst  = m_ip_dest_ip;
      hdr_misc = {m_ip_dscp, m_ip_ecn, m_ip_ttl, m_ip_protocol, m_ip_source_ip};
    end
    if (m_tvalid && m_tready) got_q.push_back({m_tkeep, m_tuser, m_tlast, m_tdata});
    if (error_arp_timeout) begin
      tmo_pulses++;
      tmo_cyc = cyc;
    end
    if (error_arp_failed) fail_pulses++;
  end

  // ---------------- ARP responder ----------------
  int rsp_mode = 0;  // 0 silent, 1 reply with MAC, 2 reply with error
  int rsp_delay = 0;
  logic [47:0] rsp_mac = '0;

  initial begin
    arp_response_valid = 1'b0;
    arp_response_error = 1'b0;
    arp_response_mac   = '0;
    forever begin
      @(negedge clk);
      if (arp_request_valid && arp_request_ready && rsp_mode != 0) begin
        @(posedge clk);
        #1;
        repeat (rsp_delay) @(posedge clk);
        #1;
        arp_response_valid = 1'b1;
        arp_response_error = (rsp_mode == 2);
        arp_response_mac   = rsp_mac;
        for (int k = 0; k < 64; k++) begin
          @(negedge clk);
          if (arp_response_ready) break;
        end
        @(posedge clk);
        #1;
        arp_response_valid = 1'b0;
        arp_response_error = 1'b0;
      end
    end
  end

  // Output-side tready: constant 1, or toggling every cycle when tog_en is set.
  bit tog_en = 1'b0;
  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (tog_en) m_tready = ~m_tready;
      else m_tready = 1'b1;
    end
  end

  // ---------------- driver / check tasks ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_hdr(input logic [31:0] dest, input logic [15:0] len);
    bit ok = 1'b0;
    s_ip_dest_ip   = dest;
    s_ip_length    = len;
    s_ip_hdr_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (s_ip_hdr_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("hdr_accept_wait", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    s_ip_hdr_valid = 1'b0;
  endtask

  task automatic send_beats(input int n, input logic [7:0] base, input bit with_last,
                            input bit expect_out);
    bit ok;
    for (int i = 0; i < n; i++) begin
      s_tdata  = base + 8'(i);
      s_tkeep  = 1'b1;
      s_tlast  = with_last && (i == n - 1);
      s_tuser  = (i == 1);
      s_tvalid = 1'b1;
      if (expect_out) exp_q.push_back({s_tkeep, s_tuser, s_tlast, s_tdata});
      ok = 1'b0;
      for (int k = 0; k < 200; k++) begin
        @(negedge clk);
        if (s_tready) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) check("beat_accept_wait", 64'd0, 64'd1);
      @(posedge clk);
      #1;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic compare_out(input string tag);
    logic [10:0] e;
    check({tag, "_beat_count"}, 64'(got_q.size() - got_idx), 64'(exp_q.size()));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (got_idx < got_q.size()) check({tag, "_beat"}, 64'(got_q[got_idx]), 64'(e));
      got_idx++;
    end
    got_idx = got_q.size();
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (s_ip_hdr_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check({tag, "_idle_wait"}, 64'd0, 64'd1);
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  int r0, h0, t0, f0;

  initial begin
    rst_n = 1'b0;
    s_ip_hdr_valid = 1'b0;
    s_ip_dscp = 6'h2E; s_ip_ecn = 2'h1; s_ip_ttl = 8'h40; s_ip_protocol = 8'h11;
    s_ip_source_ip = 32'hC0A8010A; s_ip_dest_ip = '0; s_ip_length = '0;
    s_tdata = '0; s_tkeep = '0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
    m_ip_hdr_ready = 1'b1;
    arp_request_ready = 1'b1;
    local_mac = 48'h020000000001; local_ip = 32'hC0A8010A;
    gateway_ip = 32'hC0A80101; subnet_mask = 32'hFFFFFF00;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_valids", 64'({m_ip_hdr_valid, arp_request_valid, m_tvalid}), 64'd0);
    check("rst_counters", 64'({tx_packet_count, drop_count}), 64'd0);
    check("rst_hdr_ready", 64'(s_ip_hdr_ready), 64'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    check("post_rst_hdr_ready", 64'(s_ip_hdr_ready), 64'd1);
    @(posedge clk); #1;

    // T1: on-subnet destination resolved by ARP after 5 cycles
    rsp_mode = 1; rsp_delay = 5; rsp_mac = 48'h020000000020;
    r0 = req_cnt;
    send_hdr(32'hC0A80114, 16'd24);
    send_beats(4, 8'hA0, 1'b1, 1'b1);
    @(negedge clk);
    check("t1_hdr_ready_after_tlast", 64'(s_ip_hdr_ready), 64'd1);
    @(posedge clk); #1;
    check("t1_req_count", 64'(req_cnt - r0), 64'd1);
    check("t1_req_ip", 64'(last_req_ip), 64'hC0A80114);
    check("t1_dest_mac", 64'(hdr_mac), 64'h020000000020);
    check("t1_src_mac", 64'(hdr_src), 64'h020000000001);
    check("t1_eth_type", 64'(hdr_type), 64'h0800);
    check("t1_ip_dest", 64'(hdr_dst), 64'hC0A80114);
    check("t1_ip_length", 64'(hdr_len), 64'd24);
    check("t1_ip_misc", 64'(hdr_misc), 64'({6'h2E, 2'h1, 8'h40, 8'h11, 32'hC0A8010A}));
    compare_out("t1");
    check("t1_tx_count", 64'(tx_packet_count), 64'd1);

    // T2: off-subnet destination goes to the gateway; header held until ready
    rsp_mode = 1; rsp_delay = 3; rsp_mac = 48'h020000000030;
    m_ip_hdr_ready = 1'b0;
    r0 = req_cnt;
    send_hdr(32'h08080808, 16'd30);
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("t2_hdr_valid_held", 64'(m_ip_hdr_valid), 64'd1);
    check("t2_busy", 64'(busy), 64'd1);
    @(posedge clk); #1; m_ip_hdr_ready = 1'b1;
    send_beats(3, 8'hB0, 1'b1, 1'b1);
    wait_idle("t2");
    check("t2_req_ip", 64'(last_req_ip), 64'hC0A80101);
    check("t2_req_count", 64'(req_cnt - r0), 64'd1);
    check("t2_dest_mac", 64'(hdr_mac), 64'h020000000030);
    compare_out("t2");
    check("t2_tx_count", 64'(tx_packet_count), 64'd2);

    // T3: multicast, no ARP
    r0 = req_cnt;
    send_hdr(32'hEF010203, 16'd22);
    send_beats(2, 8'hC0, 1'b1, 1'b1);
    wait_idle("t3");
    check("t3_req_count", 64'(req_cnt - r0), 64'd0);
    check("t3_dest_mac", 64'(hdr_mac), 64'h01005E010203);
    compare_out("t3");

    // T4: subnet-directed broadcast, then limited broadcast
    send_hdr(32'hC0A801FF, 16'd21);
    send_beats(1, 8'hD0, 1'b1, 1'b1);
    wait_idle("t4a");
    check("t4a_dest_mac", 64'(hdr_mac), 64'hFFFFFFFFFFFF);
    hdr_mac = '0;
    send_hdr(32'hFFFFFFFF, 16'd21);
    send_beats(1, 8'hD8, 1'b1, 1'b1);
    wait_idle("t4b");
    check("t4b_dest_mac", 64'(hdr_mac), 64'hFFFFFFFFFFFF);
    check("t4_req_count", 64'(req_cnt - r0), 64'd0);
    compare_out("t4");
    check("t4_tx_count", 64'(tx_packet_count), 64'd5);

    // T5: no ARP response -> 3 requests, 17 cycles apart, then timeout and drop
    rsp_mode = 0;
    r0 = req_cnt; h0 = hdr_cnt; t0 = tmo_pulses; f0 = fail_pulses;
    send_hdr(32'hC0A80114, 16'd23);
    send_beats(3, 8'hE0, 1'b1, 1'b0);
    wait_idle("t5");
    check("t5_req_count", 64'(req_cnt - r0), 64'd3);
    if (req_cnt - r0 == 3) begin
      check("t5_req_gap1", 64'(req_cyc[r0 + 1] - req_cyc[r0]), 64'(TMO + 1));
      check("t5_req_gap2", 64'(req_cyc[r0 + 2] - req_cyc[r0 + 1]), 64'(TMO + 1));
      check("t5_timeout_cycle", 64'(tmo_cyc - req_cyc[r0 + 2]), 64'(TMO + 1));
    end
    check("t5_req_ip", 64'(last_req_ip), 64'hC0A80114);
    check("t5_timeout_pulses", 64'(tmo_pulses - t0), 64'd1);
    check("t5_failed_pulses", 64'(fail_pulses - f0), 64'd0);
    check("t5_no_hdr", 64'(hdr_cnt - h0), 64'd0);
    compare_out("t5");
    check("t5_drop_count", 64'(drop_count), 64'd1);
    check("t5_tx_count", 64'(tx_packet_count), 64'd5);

    // T6: ARP error response -> failed pulse and drop
    rsp_mode = 2; rsp_delay = 2; rsp_mac = 48'h0;
    h0 = hdr_cnt; f0 = fail_pulses; t0 = tmo_pulses;
    send_hdr(32'hC0A80133, 16'd22);
    send_beats(2, 8'hF0, 1'b1, 1'b0);
    wait_idle("t6");
    check("t6_failed_pulses", 64'(fail_pulses - f0), 64'd1);
    check("t6_timeout_pulses", 64'(tmo_pulses - t0), 64'd0);
    check("t6_no_hdr", 64'(hdr_cnt - h0), 64'd0);
    compare_out("t6");
    check("t6_drop_count", 64'(drop_count), 64'd2);

    // T7: response lands in the cycle the counter reaches 0 -> accepted, no retry
    rsp_mode = 1; rsp_delay = TMO - 1; rsp_mac = 48'h0200000000AB;
    r0 = req_cnt; t0 = tmo_pulses;
    send_hdr(32'hC0A80115, 16'd21);
    send_beats(1, 8'h11, 1'b1, 1'b1);
    wait_idle("t7");
    check("t7_req_count", 64'(req_cnt - r0), 64'd1);
    check("t7_timeout_pulses", 64'(tmo_pulses - t0), 64'd0);
    check("t7_dest_mac", 64'(hdr_mac), 64'h0200000000AB);
    compare_out("t7");
    check("t7_tx_count", 64'(tx_packet_count), 64'd6);

    // T8: toggling output tready, no beat lost or duplicated
    rsp_mode = 1; rsp_delay = 1; rsp_mac = 48'h0200000000CD;
    tog_en = 1'b1;
    send_hdr(32'hC0A80116, 16'd26);
    send_beats(6, 8'h40, 1'b1, 1'b1);
    wait_idle("t8");
    tog_en = 1'b0;
    compare_out("t8");
    check("t8_tx_count", 64'(tx_packet_count), 64'd7);

    // T9: reset in the middle of a payload
    rsp_mode = 1; rsp_delay = 1; rsp_mac = 48'h0200000000EF;
    send_hdr(32'hC0A80117, 16'd24);
    send_beats(2, 8'h60, 1'b0, 1'b1);
    compare_out("t9");
    s_tvalid = 1'b1; s_tdata = 8'h62; s_tlast = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    check("t9_rst_busy", 64'(busy), 64'd0);
    check("t9_rst_valids", 64'({m_ip_hdr_valid, arp_request_valid, m_tvalid}), 64'd0);
    check("t9_rst_s_tready", 64'(s_tready), 64'd0);
    check("t9_rst_counters", 64'({tx_packet_count, drop_count}), 64'd0);
    check("t9_rst_err", 64'({error_arp_failed, error_arp_timeout}), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; s_tvalid = 1'b0;
    @(posedge clk); @(negedge clk);
    check("t9_hdr_ready_after_rst", 64'(s_ip_hdr_ready), 64'd1);
    check("t9_busy_after_rst", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
